// File: rtl/mem_responder.sv
// Memory-side responder for the tagged cache bus: same-cycle tag allocation for loads,
// fixed-latency return of a snapshot of the addressed 64-bit word.
module mem_responder #(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned NUM_TAGS  = 15,
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  proc2mem_command,
  input  logic [31:0] proc2mem_addr,
  input  logic [63:0] proc2mem_data,
  output logic [3:0]  mem2proc_response,
  output logic        mem2proc_response_valid,
  output logic [63:0] mem2proc_data,
  output logic [3:0]  mem2proc_tag
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2,
    BUS_RSVD  = 2'd3
  } bus_cmd_e;

  bus_cmd_e          cmd;
  logic [AW-1:0]     word_idx;
  logic [63:0]       mem [MEM_WORDS];
  logic [NUM_TAGS:1] busy;
  logic [3:0]        alloc_tag;
  logic              accept;
  logic [3:0]        pipe_tag  [LATENCY];
  logic [63:0]       pipe_data [LATENCY];
  logic              unused_addr;

  assign cmd         = bus_cmd_e'(proc2mem_command);
  assign word_idx    = proc2mem_addr[3 +: AW];
  assign unused_addr = ^{proc2mem_addr[2:0], proc2mem_addr[31:3+AW]};

  // Lowest free tag wins; a tag presenting its data this cycle is already free.
  always_comb begin
    alloc_tag = '0;
    for (int unsigned t = NUM_TAGS; t >= 1; t--) begin
      if (!busy[t] || mem2proc_tag == 4'(t)) alloc_tag = 4'(t);
    end
  end

  always_comb begin
    accept                  = (cmd == BUS_LOAD) && (alloc_tag != '0);
    mem2proc_response       = accept ? alloc_tag : '0;
    mem2proc_response_valid = (cmd == BUS_LOAD) || (cmd == BUS_STORE);
  end

  // Allocation takes priority over the release of a tag being reused in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      for (int unsigned t = 1; t <= NUM_TAGS; t++) begin
        if (accept && alloc_tag == 4'(t)) busy[t] <= 1'b1;
        else if (mem2proc_tag == 4'(t))   busy[t] <= 1'b0;
      end
    end
  end

  // Tag 0 doubles as the valid bit; empty slots carry zero data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_tag[i]  <= '0;
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_tag[0]  <= accept ? alloc_tag : '0;
      pipe_data[0] <= accept ? mem[word_idx] : '0;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_tag[i]  <= pipe_tag[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (cmd == BUS_STORE) mem[word_idx] <= proc2mem_data;
  end

  assign mem2proc_tag  = pipe_tag[LATENCY-1];
  assign mem2proc_data = pipe_data[LATENCY-1];

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable memory-side responder for the tagged memory bus used by the instruction and data caches.
- Accepts one BUS_LOAD or BUS_STORE command per cycle and returns an acceptance tag combinationally in the same cycle.
- Delivers 64-bit load data exactly LATENCY cycles later, stamped with that tag.
- Stands in for main memory during block-level and system simulation and in synthesis of the cache subsystem.

Parameters:
- LATENCY, 4: cycles from load acceptance edge to data/tag presentation; legal range 1..16.
- NUM_TAGS, 15: number of allocatable tags (values 1..NUM_TAGS); legal range 1..15; tag 0 is reserved for "none".
- MEM_WORDS, 256: depth of the 64-bit storage array; power of two.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- proc2mem_command  in  BUS_COMMAND (2)  BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2; value 3 is treated as BUS_NONE.
- proc2mem_addr  in  `XLEN (32)  byte address; bits [2:0] ignored; word index = addr[3 +: log2(MEM_WORDS)], upper bits wrap.
- proc2mem_data  in  64  store data.
- mem2proc_response  out  4  combinational: allocated tag for an accepted load; 0 for a rejected load, a store, or no command.
- mem2proc_response_valid  out  1  combinational: 1 whenever the command is not BUS_NONE.
- mem2proc_data  out  64  registered load data; 0 when mem2proc_tag is 0.
- mem2proc_tag  out  4  registered: nonzero for exactly one cycle when data for that tag is presented.

Behaviour:
- Reset (reset=0, asynchronous):
  - mem2proc_tag=0, mem2proc_data=0.
  - Return pipeline cleared; all tags freed.
  - Storage array contents are not reset.
  - Reset mid-flight discards every outstanding load; no tag is returned after reset deasserts.
- Tag pool:
  - busy bit per tag 1..NUM_TAGS.
  - A load is accepted if any tag is free; the lowest-numbered free tag is allocated.
  - A tag whose data is being presented this cycle (mem2proc_tag==t) counts as free for allocation this cycle.
  - Busy bit is set at the acceptance edge and cleared at the edge ending the presentation cycle, unless it was reallocated in that cycle.
- Load accepted in cycle t:
  - mem2proc_response = tag during cycle t.
  - Array word is read at the cycle-t edge (snapshot).
  - mem2proc_tag = tag and mem2proc_data = the snapshot during cycle t+LATENCY only.
- Load rejected (no free tag): mem2proc_response=0 and mem2proc_response_valid=1. The requester retries; no state change.
- Store in cycle t:
  - Always accepted; mem2proc_response=0.
  - Array word written at the cycle-t edge.
  - Consumes no tag and produces no return.
- Ordering:
  - Returns are in acceptance order, at most one per cycle. The pipeline is LATENCY entries of {valid, tag, data}, shifting every cycle.
  - Load at cycle t+1 after a store at t to the same word returns the new data.
  - Store at t+1 after a load at t to the same word does not affect that load's data.
- Outstanding loads never exceed min(NUM_TAGS, LATENCY).
- The response path is purely combinational from command and tag-pool state. There is no registered stall and no backpressure on returns.

Test Plan:
- Reset, then hold reset=0 for 3 cycles with BUS_LOAD asserted -> mem2proc_tag=0 and mem2proc_data=0 throughout; no tag is returned LATENCY cycles after release.
- BUS_STORE addr 0x40 data 0xDEADBEEF_CAFEF00D, next cycle BUS_LOAD 0x44 -> response=1 and response_valid=1 in the load cycle; 4 cycles later tag=1 and data=0xDEADBEEF_CAFEF00D for exactly one cycle.
- Back-to-back loads to addrs 0x0, 0x8, 0x10, 0x18, 0x20 (preloaded with 1..5) -> responses 1,2,3,4, then 1 (tag 1 freed and reused in the same cycle); returns tags 1,2,3,4,1 with data 1..5 on consecutive cycles.
- NUM_TAGS=2, LATENCY=4, loads in 3 consecutive cycles -> responses 1, 2, 0 with response_valid=1 on all three; retrying the third load in the cycle tag 1 returns -> response=1.
- Load addr 0x80 at cycle t, then store 0x80 with new data at t+1 -> the return at t+4 carries the old value; a load at t+2 returns the new value at t+6.
- Assert reset with 3 loads outstanding, release, issue one load -> no stale tags appear; the new load gets response=1 and returns correct data after LATENCY.
